// File: rtl/pipelined_magnitude_comparator_pkg.sv
// Shared types for the pipelined magnitude comparator: result encoding, per-stage state, and stage count.
package cmp_pkg;

  typedef enum logic [1:0] {
    RES_EQ = 2'd0,
    RES_GT = 2'd1,
    RES_LT = 2'd2
  } res_e;

  typedef struct packed {
    logic valid;
    logic decided;
    logic gt;
    logic lt;
  } stage_t;

  function automatic int nstages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_magnitude_comparator_if.sv
// Operand/result handshake bundle; master drives operands and out_ready, slave is the comparator.
interface pipelined_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  import cmp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             a_grt_b;
  logic             a_less_b;
  logic             a_eq_b;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, a_grt_b, a_less_b, a_eq_b
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, a_grt_b, a_less_b, a_eq_b
  );

endinterface

// File: rtl/pipelined_magnitude_comparator_stage.sv
// One CHUNK-wide slice of the MSB-first compare plus its pipeline register; one cycle, holds while i_hold.
// Consumed operand bits are dropped, so each stage carries only the bits still to be examined.
module cmp_stage
  import cmp_pkg::*;
#(
  parameter int CHUNK = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = (IN_W > CHUNK) ? IN_W - CHUNK : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hold,
  input  stage_t           i_st,
  input  logic [IN_W-1:0]  i_a,
  input  logic [IN_W-1:0]  i_b,
  output stage_t           o_st,
  output logic [OUT_W-1:0] o_a,
  output logic [OUT_W-1:0] o_b
);

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  stage_t           w_nxt;
  stage_t           r_st;

  assign w_ca = i_a[IN_W-1 -: CHUNK];
  assign w_cb = i_b[IN_W-1 -: CHUNK];

  // The first differing chunk decides; later stages just forward the verdict.
  always_comb begin
    w_nxt = i_st;
    if (!i_st.decided) begin
      if (w_ca > w_cb) begin
        w_nxt.decided = 1'b1;
        w_nxt.gt      = 1'b1;
      end else if (w_ca < w_cb) begin
        w_nxt.decided = 1'b1;
        w_nxt.lt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= '0;
    end else if (!i_hold) begin
      r_st <= w_nxt;
    end
  end

  assign o_st = r_st;

  if (IN_W > CHUNK) begin : g_rest
    logic [OUT_W-1:0] r_a;
    logic [OUT_W-1:0] r_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_a <= '0;
        r_b <= '0;
      end else if (!i_hold) begin
        r_a <= i_a[IN_W-CHUNK-1:0];
        r_b <= i_b[IN_W-CHUNK-1:0];
      end
    end

    assign o_a = r_a;
    assign o_b = r_b;
  end else begin : g_last
    assign o_a = '0;
    assign o_b = '0;
  end

endmodule

// File: rtl/pipelined_magnitude_comparator.sv
// WIDTH-bit signed/unsigned compare, CHUNK bits per stage MSB-first; NSTAGES-cycle latency, one result/cycle.
// An output stall freezes every stage including bubbles; defining CMP_STATS_EN adds saturating result counters.
module pipelined_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic clk,
  input logic rst,
  pipelined_magnitude_comparator_if.slave bus
`ifdef CMP_STATS_EN
  ,
  output logic [15:0] cnt_gt,
  output logic [15:0] cnt_lt,
  output logic [15:0] cnt_eq
`endif
);

  localparam int NSTAGES = nstages(WIDTH, CHUNK);

  logic             w_stall;
  logic             w_accept;
  logic [WIDTH-1:0] w_a_entry;
  logic [WIDTH-1:0] w_b_entry;
  stage_t           w_st [NSTAGES+1];
  stage_t           w_last;
  res_e             w_res;

  assign w_last       = w_st[NSTAGES];
  assign w_stall      = w_last.valid && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign w_accept     = bus.in_valid && !w_stall;

  // Flipping the sign bits maps two's complement onto offset binary, so every stage stays unsigned.
  assign w_a_entry = bus.is_signed ? {~bus.a[WIDTH-1], bus.a[WIDTH-2:0]} : bus.a;
  assign w_b_entry = bus.is_signed ? {~bus.b[WIDTH-1], bus.b[WIDTH-2:0]} : bus.b;
  assign w_st[0]   = '{valid: w_accept, decided: 1'b0, gt: 1'b0, lt: 1'b0};

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    localparam int IN_W  = WIDTH - k * CHUNK;
    localparam int OUT_W = (IN_W > CHUNK) ? IN_W - CHUNK : 1;

    logic [IN_W-1:0]  w_a_in;
    logic [IN_W-1:0]  w_b_in;
    logic [OUT_W-1:0] w_a_out;
    logic [OUT_W-1:0] w_b_out;

    if (k == 0) begin : g_head
      assign w_a_in = w_a_entry;
      assign w_b_in = w_b_entry;
    end else begin : g_body
      assign w_a_in = g_stage[k-1].w_a_out;
      assign w_b_in = g_stage[k-1].w_b_out;
    end

    if (k == NSTAGES - 1) begin : g_tail
      logic w_unused_rest;
      assign w_unused_rest = ^{w_a_out, w_b_out};
    end

    cmp_stage #(
      .CHUNK (CHUNK),
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_hold (w_stall),
      .i_st   (w_st[k]),
      .i_a    (w_a_in),
      .i_b    (w_b_in),
      .o_st   (w_st[k+1]),
      .o_a    (w_a_out),
      .o_b    (w_b_out)
    );
  end

  always_comb begin
    w_res = RES_EQ;
    if (w_last.decided) begin
      w_res = w_last.gt ? RES_GT : RES_LT;
    end
  end

  assign bus.out_valid = w_last.valid;
  assign bus.a_grt_b   = w_last.valid && (w_res == RES_GT);
  assign bus.a_less_b  = w_last.valid && (w_res == RES_LT);
  assign bus.a_eq_b    = w_last.valid && (w_res == RES_EQ);

`ifdef CMP_STATS_EN
  logic        w_xfer;
  logic [15:0] r_cnt_gt;
  logic [15:0] r_cnt_lt;
  logic [15:0] r_cnt_eq;

  assign w_xfer = w_last.valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_gt <= '0;
      r_cnt_lt <= '0;
      r_cnt_eq <= '0;
    end else if (w_xfer) begin
      case (w_res)
        RES_GT:  if (r_cnt_gt != 16'hFFFF) r_cnt_gt <= r_cnt_gt + 16'd1;
        RES_LT:  if (r_cnt_lt != 16'hFFFF) r_cnt_lt <= r_cnt_lt + 16'd1;
        default: if (r_cnt_eq != 16'hFFFF) r_cnt_eq <= r_cnt_eq + 16'd1;
      endcase
    end
  end

  assign cnt_gt = r_cnt_gt;
  assign cnt_lt = r_cnt_lt;
  assign cnt_eq = r_cnt_eq;
`endif

endmodule

// File: tb/tb_pipelined_magnitude_comparator.sv
// Directed bench for pipelined_magnitude_comparator: scoreboard of expected flags, checked on every output transfer.
module tb_pipelined_magnitude_comparator;

  localparam int WIDTH   = 16;
  localparam int CHUNK   = 4;
  localparam int NSTAGES = WIDTH / CHUNK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipelined_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

`ifdef CMP_STATS_EN
  logic [15:0] cnt_gt;
  logic [15:0] cnt_lt;
  logic [15:0] cnt_eq;
`endif

  pipelined_magnitude_comparator #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus)
`ifdef CMP_STATS_EN
    ,
    .cnt_gt (cnt_gt),
    .cnt_lt (cnt_lt),
    .cnt_eq (cnt_eq)
`endif
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [2:0] sb[$];
  int         out_cyc[$];
  logic [2:0] flags;

  assign flags = {bus.a_grt_b, bus.a_less_b, bus.a_eq_b};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference compare straight from the definition: {gt, lt, eq}.
  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic gt;
    logic lt;
    if (s) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return {gt, lt, !gt && !lt};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          chk("result_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) chk("result", flags, sb.pop_front());
          out_cyc.push_back(cyc);
        end
      end else begin
        chk("idle_flags", flags, 0);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s);
    int   waits = 0;
    logic ok    = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    while (!ok && waits < 100) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    chk("accept_in_time", ok, 1);
    if (ok) sb.push_back(model(a, b, s));
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_midflight(input logic stall, input string tag);
    int n = 0;
    int base;
    bus.out_ready = !stall;
    send(16'h0005, 16'h0003, 1'b0);
    send(16'h0003, 16'h0005, 1'b0);
    if (stall) begin
      while (!bus.out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk({tag, "_stall_reached"}, bus.out_valid, 1);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_flags"}, flags, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    bus.out_ready = 1'b1;
    base = out_cyc.size();
    repeat (12) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_no_stale"}, out_cyc.size() - base, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         base;
    int         n;
    logic [2:0] exp1;
    logic [15:0] ra;
    logic [15:0] rb;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_flags", flags, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Latency: the accept edge counts as the first of NSTAGES edges.
    send(16'h1234, 16'h1235, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, NSTAGES);
    chk("lt_1234_1235", flags, 3'b010);
    drain("drain_basic");

    send(16'hFFFF, 16'hFFFF, 1'b0);
    drain("drain_all_ones");

    // Same bit patterns, opposite verdicts depending on mode; results must be adjacent.
    base = out_cyc.size();
    send(16'h8000, 16'h7FFF, 1'b1);
    send(16'h8000, 16'h7FFF, 1'b0);
    drain("drain_signed");
    chk("signed_pair_count", out_cyc.size() - base, 2);
    if (out_cyc.size() - base == 2) chk("signed_pair_adjacent", out_cyc[base+1] - out_cyc[base], 1);

    base = out_cyc.size();
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = (i % 4 == 0) ? ra : 16'($urandom);
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    drain("drain_stream");
    chk("stream_count", out_cyc.size() - base, 10);
    if (out_cyc.size() - base == 10) chk("stream_consecutive", out_cyc[base+9] - out_cyc[base], 9);

    // Backpressure: three in flight, output blocked five cycles, a fourth pair waiting at the input.
    base = out_cyc.size();
    bus.out_ready = 1'b0;
    exp1 = model(16'h00F0, 16'h000F, 1'b0);
    send(16'h00F0, 16'h000F, 1'b0);
    send(16'h1111, 16'h2222, 1'b0);
    send(16'hABCD, 16'hABCD, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid  = 1'b1;
    bus.a         = 16'h0001;
    bus.b         = 16'h0002;
    bus.is_signed = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_hold", flags, exp1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(16'h0001, 16'h0002, 1'b1);
    drain("drain_backpressure");
    chk("bp_count", out_cyc.size() - base, 4);

    rst_midflight(1'b0, "rst_flight");
    rst_midflight(1'b1, "rst_stall");

`ifdef CMP_STATS_EN
    chk("cnt_gt_after_rst", cnt_gt, 0);
    chk("cnt_lt_after_rst", cnt_lt, 0);
    chk("cnt_eq_after_rst", cnt_eq, 0);
    send(16'h0009, 16'h0001, 1'b0);
    send(16'h0001, 16'hFFFF, 1'b1);
    send(16'hF000, 16'h0F00, 1'b0);
    send(16'h0001, 16'h0009, 1'b0);
    send(16'hFFFF, 16'h0001, 1'b1);
    send(16'h5A5A, 16'h5A5A, 1'b0);
    drain("drain_stats");
    chk("cnt_gt", cnt_gt, 3);
    chk("cnt_lt", cnt_lt, 2);
    chk("cnt_eq", cnt_eq, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("cnt_gt_cleared", cnt_gt, 0);
    chk("cnt_lt_cleared", cnt_lt, 0);
    chk("cnt_eq_cleared", cnt_eq, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_magnitude_comparator.md
Name: pipelined_magnitude_comparator

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per pipeline stage, with per-transaction signed/unsigned mode.
- Uses a valid/ready handshake on both sides.
- Sits in datapaths where a single-cycle wide compare would break timing. Examples: threshold checks and sort/select networks.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 4, bits resolved per stage; NSTAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept a pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- a_grt_b  output  1  A > B.
- a_less_b  output  1  A < B.
- a_eq_b  output  1  A == B.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All stage valid bits clear, out_valid=0, a_grt_b=a_less_b=a_eq_b=0.
  - In-flight transactions are discarded.
  - in_ready=1 in the first cycle after reset.
- Accept: a transfer happens when in_valid && in_ready. An output transfer happens when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall.
  - While stalled, every stage register holds, including the bubbles.
  - Otherwise the whole pipeline advances one stage per cycle. There is no bubble collapse.
- Signed handling: at entry, if is_signed=1, the MSB of both a and b is inverted (offset-binary form). All stages then do an unsigned compare.
- Stage k (k = 0..NSTAGES-1):
  - Examines chunk bits [WIDTH-1-k*CHUNK -: CHUNK].
  - Carries a decided flag plus gt and lt bits.
  - If not yet decided: chunk_a > chunk_b sets gt and decided; chunk_a < chunk_b sets lt and decided; equal chunks leave the flags unchanged.
  - Once decided, later stages pass the flags unchanged.
  - Operand bits already consumed are dropped from the pipeline registers.
- Output:
  - After the last stage: a_grt_b = gt, a_less_b = lt, a_eq_b = !gt && !lt.
  - Exactly one flag is high whenever out_valid=1. All three are 0 when out_valid=0.
- Latency: NSTAGES cycles from the accept edge to out_valid=1, with no stalls. Default is 4.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: results leave in acceptance order.
- Boundary conditions:
  - a == b, all ones: a_eq_b.
  - 0x8000 vs 0x7FFF signed: a_less_b.
  - 0x8000 vs 0x7FFF unsigned: a_grt_b.
  - in_valid while stalled: the pair is not accepted, and the source must hold it.
  - rst asserted mid-stall: outputs clear on the next edge and the held result is lost.
  - in_valid=0: a bubble advances. out_valid is driven by the last stage's valid bit.

Optional Feature:
- Macro: CMP_STATS_EN.
- When defined, three extra outputs are added: cnt_gt, cnt_lt, cnt_eq, each 16 bits.
  - Each counts results transferred (out_valid && out_ready) with the matching flag.
  - Counts saturate at 0xFFFF.
  - All clear on rst.
- When undefined, these ports and counters do not exist, and the datapath behaviour is identical.

Decomposition:
- Package cmp_pkg holds:
  - the 2-bit result encoding (RES_EQ=0, RES_GT=1, RES_LT=2);
  - a function nstages(WIDTH, CHUNK);
  - the stage-state typedef {valid, decided, gt, lt}.
- Sub-module cmp_stage: one chunk compare plus its pipeline register, with a hold input. The top level generates NSTAGES instances.

Test Plan:
- Unsigned basic: a=0x1234, b=0x1235, is_signed=0, out_ready=1 -> 4 cycles later out_valid=1 and a_less_b=1. Then a=0xFFFF, b=0xFFFF -> a_eq_b=1.
- Signed vs unsigned: a=0x8000, b=0x7FFF, first with is_signed=1 then with is_signed=0 -> a_less_b=1, then a_grt_b=1, on consecutive output cycles.
- Streaming: 10 back-to-back random pairs with out_ready=1 -> 10 results on consecutive cycles, in order, each matching a reference model.
- Backpressure: issue 3 pairs, hold out_ready=0 for 5 cycles -> in_ready=0 while out_valid=1, outputs stable. Release -> results drain in order, with no loss or duplication.
- Reset mid-flight: accept 2 pairs, assert rst for 1 cycle -> out_valid=0 and all flags 0 on the next edge, no stale result ever appears, in_ready=1.
- With CMP_STATS_EN: send 3 gt, 2 lt, 1 eq -> cnt_gt=3, cnt_lt=2, cnt_eq=1. Counters are 0 after rst.
